// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates an instruction-fetch port and a
// load/store port onto one 8-bit single-port RAM with a one-cycle read latency.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_wr
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic {P_IF = 1'b0, P_D = 1'b1} port_t;

  state_t      r_state, w_state;
  port_t       r_last, w_last, r_port, w_port;
  logic [1:0]  r_cnt, w_cnt, r_last_idx, w_last_idx;
  logic        r_tail, w_tail, r_we, w_we;
  logic [16:0] r_addr, w_addr;
  logic [31:0] r_wdata, w_wdata, r_asm, w_asm;
  logic [31:0] r_if_inst, w_if_inst, r_d_rdata, w_d_rdata;
  logic        w_if_ok;
  logic [4:0]  w_wr_base, w_rd_base;
  logic        w_unused;

  assign w_if_ok   = if_req & ~if_flush;
  assign w_wr_base = {r_cnt, 3'b000};
  // In the tail cycle r_cnt still holds N-1, which is the byte arriving now.
  assign w_rd_base = r_tail ? {r_cnt, 3'b000} : {r_cnt - 2'd1, 3'b000};
  assign w_unused  = ^{if_addr[31:17], d_addr[31:17]};

  assign if_inst = r_if_inst;
  assign d_rdata = r_d_rdata;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    w_state    = r_state;
    w_last     = r_last;
    w_port     = r_port;
    w_cnt      = r_cnt;
    w_last_idx = r_last_idx;
    w_tail     = r_tail;
    w_we       = r_we;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_asm      = r_asm;
    w_if_inst  = r_if_inst;
    w_d_rdata  = r_d_rdata;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_dout   = '0;
    if_done    = 1'b0;
    d_done     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (d_req && (!w_if_ok || r_last == P_IF)) begin
          w_port  = P_D;
          w_addr  = d_addr[16:0];
          w_we    = d_we;
          w_wdata = d_wdata;
          unique case (d_size)
            2'b00:   w_last_idx = 2'd0;
            2'b01:   w_last_idx = 2'd1;
            default: w_last_idx = 2'd3;
          endcase
        end else if (w_if_ok) begin
          w_port     = P_IF;
          w_addr     = if_addr[16:0];
          w_we       = 1'b0;
          w_wdata    = '0;
          w_last_idx = 2'd3;
        end
        if (d_req || w_if_ok) begin
          w_state = S_BUSY;
          w_cnt   = 2'd0;
          w_tail  = 1'b0;
          w_asm   = '0;
          w_last  = w_port;
        end
      end

      S_BUSY: begin
        if (r_tail) begin
          w_asm[w_rd_base +: 8] = mem_din;
          if (r_port == P_IF) w_if_inst = w_asm;
          else                w_d_rdata = w_asm;
          w_state = S_DONE;
        end else begin
          mem_addr = r_addr + 17'(r_cnt);
          mem_wr   = r_we;
          if (r_we)                 mem_dout = r_wdata[w_wr_base +: 8];
          else if (r_cnt != 2'd0)   w_asm[w_rd_base +: 8] = mem_din;
          if (r_cnt == r_last_idx) begin
            if (r_we) w_state = S_DONE;
            else      w_tail  = 1'b1;
          end else begin
            w_cnt = r_cnt + 2'd1;
          end
        end
        // A PC change abandons the fetch outright; the partial word is dropped.
        if (r_port == P_IF && if_flush) begin
          w_state   = S_IDLE;
          w_tail    = 1'b0;
          w_asm     = '0;
          w_if_inst = r_if_inst;
        end
      end

      S_DONE: begin
        if_done = (r_port == P_IF);
        d_done  = (r_port == P_D);
        w_state = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_last     <= P_IF;
      r_port     <= P_IF;
      r_cnt      <= '0;
      r_last_idx <= '0;
      r_tail     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_asm      <= '0;
      r_if_inst  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state;
      r_last     <= w_last;
      r_port     <= w_port;
      r_cnt      <= w_cnt;
      r_last_idx <= w_last_idx;
      r_tail     <= w_tail;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_asm      <= w_asm;
      r_if_inst  <= w_if_inst;
      r_d_rdata  <= w_d_rdata;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural RAM, shadow memory model and
// per-port scoreboards popped on each done pulse.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, if_done;
  logic [31:0] if_addr = '0, if_inst;
  logic        d_req = 1'b0, d_we = 1'b0, d_done;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [16:0] mem_addr;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_wr;

  always #5 clk = ~clk;

  mem_ctrl u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din), .mem_wr(mem_wr)
  );

  // Single-port RAM with registered read; pokes preload it while the DUT is idle.
  logic [7:0]  ram [0:131071] = '{default: 8'h00};
  logic [7:0]  model [0:131071];
  logic        poke_en = 1'b0;
  logic [16:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  always @(posedge clk) begin
    if (poke_en)     ram[poke_addr] <= poke_data;
    else if (mem_wr) ram[mem_addr]  <= mem_dout;
    mem_din <= ram[mem_addr];
  end

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } sb_t;

  sb_t d_q[$];
  sb_t if_q[$];
  sb_t mon_e;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done = 0, n_d_done = 0, n_if_done = 0;
  logic [31:0] order_bits = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (d_done) begin
        n_done++;
        n_d_done++;
        order_bits = {order_bits[30:0], 1'b1};
        check("d_sb_nonempty", 32'(d_q.size() != 0), 32'd1);
        if (d_q.size() != 0) begin
          mon_e = d_q.pop_front();
          if (mon_e.chk) check("d_rdata", d_rdata, mon_e.data);
        end
      end
      if (if_done) begin
        n_done++;
        n_if_done++;
        order_bits = {order_bits[30:0], 1'b0};
        check("if_sb_nonempty", 32'(if_q.size() != 0), 32'd1);
        if (if_q.size() != 0) begin
          mon_e = if_q.pop_front();
          check("if_inst", if_inst, mon_e.data);
        end
      end
    end
  end

  task automatic poke(input logic [16:0] a, input logic [7:0] v);
    model[a]  = v;
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = v;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] addr, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = model[17'(addr + 32'(i))];
    return v;
  endfunction

  // Drives one transaction from posedge+1 and checks the RAM-side cycles and the
  // done latency; returns at posedge+1 with the request dropped.
  task automatic run_txn(input bit is_d, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int  n, lat, got_lat;
    bit  seen;
    sb_t e;
    n   = !is_d ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    lat = we ? n + 1 : n + 2;
    if (we) for (int i = 0; i < n; i++) model[17'(addr + 32'(i))] = wdata[8*i +: 8];
    e.chk  = !we;
    e.data = we ? 32'd0 : model_word(addr, n);
    if (is_d) begin
      d_q.push_back(e);
      d_we = we; d_size = size; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      if_q.push_back(e);
      if_addr = addr; if_req = 1'b1;
    end
    @(posedge clk);
    seen    = 1'b0;
    got_lat = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (k <= n) begin
        check("mem_addr", 32'(mem_addr), 32'(17'(addr + 32'(k - 1))));
        check("mem_wr", 32'(mem_wr), 32'(we));
        if (we) check("mem_dout", 32'(mem_dout), 32'(wdata[8*(k-1) +: 8]));
      end
      if (is_d ? d_done : if_done) begin
        seen    = 1'b1;
        got_lat = k;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", got_lat, lat);
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0;
    else      if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  base_if, base_d, k_done;
    bit  seen;
    sb_t e;

    for (int i = 0; i < 131072; i++) model[i] = 8'h00;
    #1 rst = 1'b0;
    #1;
    check("rst_mem_wr",   32'(mem_wr),   32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_if_done",  32'(if_done),  32'd0);
    check("rst_d_done",   32'(d_done),   32'd0);
    check("rst_if_inst",  if_inst,       32'd0);
    check("rst_d_rdata",  d_rdata,       32'd0);

    @(posedge clk); #1;
    poke(17'h00010, 8'h13); poke(17'h00011, 8'h05);
    poke(17'h00012, 8'h00); poke(17'h00013, 8'h00);
    poke(17'h00105, 8'h55);
    poke(17'h1FFFE, 8'hAA); poke(17'h1FFFF, 8'hBB);
    poke(17'h00000, 8'hCC); poke(17'h00001, 8'hDD);
    poke(17'h00500, 8'h11); poke(17'h00501, 8'h22);
    poke(17'h00502, 8'h33); poke(17'h00503, 8'h44);
    poke(17'h00600, 8'h01); poke(17'h00601, 8'h02);
    poke(17'h00602, 8'h03); poke(17'h00603, 8'h04);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0);
    run_txn(1'b1, 1'b1, 2'b00, 32'h0000_0104, 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b0, 2'b00, 32'h0000_0104, 32'h0);
    run_txn(1'b1, 1'b0, 2'b01, 32'h0000_0104, 32'h0);
    run_txn(1'b1, 1'b1, 2'b01, 32'h0000_0204, 32'hCAFE_F00D);
    run_txn(1'b1, 1'b0, 2'b10, 32'h0000_0204, 32'h0);
    run_txn(1'b1, 1'b1, 2'b10, 32'h0000_0208, 32'h1234_5678);
    run_txn(1'b1, 1'b0, 2'b11, 32'h0000_0208, 32'h0);
    run_txn(1'b1, 1'b0, 2'b10, 32'h0001_FFFE, 32'h0);

    // Both ports held high from reset: expect D, IF, D, IF.
    rst = 1'b0;
    if_addr = 32'h10; if_req = 1'b1;
    d_we = 1'b0; d_size = 2'b10; d_addr = 32'h600; d_req = 1'b1;
    e.chk = 1'b1;
    e.data = model_word(32'h10, 4);  if_q.push_back(e); if_q.push_back(e);
    e.data = model_word(32'h600, 4); d_q.push_back(e);  d_q.push_back(e);
    order_bits = '0;
    n_done = 0;
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 80 && n_done < 4; c++) @(negedge clk);
    d_req = 1'b0;
    if_req = 1'b0;
    repeat (10) @(negedge clk);
    check("tie_done_count", n_done, 4);
    check("tie_order", order_bits, 32'b1010);
    @(posedge clk); #1;

    // Flush an in-flight fetch in cycle 3 while a load waits.
    base_if = n_if_done;
    if_addr = 32'h40; if_req = 1'b1;
    @(posedge clk); #1;
    d_we = 1'b0; d_size = 2'b10; d_addr = 32'h500; d_req = 1'b1;
    e.chk = 1'b1; e.data = model_word(32'h500, 4); d_q.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_flush = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    if_flush = 1'b0;
    @(negedge clk);
    check("flush_idle_addr", 32'(mem_addr), 32'd0);
    check("flush_idle_wr",   32'(mem_wr),   32'd0);
    @(negedge clk);
    check("flush_d_addr", 32'(mem_addr), 32'h500);
    seen = 1'b0;
    k_done = 0;
    for (int c = 6; c <= 25 && !seen; c++) begin
      @(negedge clk);
      if (d_done) begin
        seen = 1'b1;
        k_done = c;
      end
    end
    check("flush_d_seen", 32'(seen), 32'd1);
    check("flush_d_cycle", k_done, 10);
    @(posedge clk); #1 d_req = 1'b0;
    check("flush_no_if_done", n_if_done, base_if);

    // Reset during cycle 2 of a word store: only byte 0 reaches the RAM.
    base_d = n_d_done;
    d_we = 1'b1; d_size = 2'b10; d_addr = 32'h300; d_wdata = 32'h1122_3344; d_req = 1'b1;
    model[17'h300] = 8'h44;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rstmid_mem_wr",   32'(mem_wr),   32'd0);
    check("rstmid_mem_addr", 32'(mem_addr), 32'd0);
    check("rstmid_mem_dout", 32'(mem_dout), 32'd0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_d_rdata", d_rdata, 32'd0);
    check("rstmid_if_inst", if_inst, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_no_d_done", n_d_done, base_d);
    run_txn(1'b1, 1'b0, 2'b10, 32'h0000_0300, 32'h0);

    check("sb_d_drained",  d_q.size(),  0);
    check("sb_if_drained", if_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 if_req  in  1  instruction-fetch request; held high until if_done.
REQ-004 if_addr  in  32  fetch byte address; stable while if_req high.
REQ-005 if_flush  in  1  PC-change flush; aborts a pending or in-flight fetch.
REQ-006 if_done  out  1  one-cycle pulse; if_inst valid in the same cycle.
REQ-007 if_inst  out  32  fetched word, little-endian.
REQ-008 d_req  in  1  load/store request; held high until d_done.
REQ-009 d_we  in  1  1 = store, 0 = load.
REQ-010 d_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  store data; byte 0 is bits 7:0.
REQ-013 d_done  out  1  one-cycle pulse; d_rdata valid in the same cycle for loads.
REQ-014 d_rdata  out  32  load data, zero-extended above d_size.
REQ-015 mem_addr  out  17  byte address to the single-port RAM.
REQ-016 mem_dout  out  8  write byte to the RAM.
REQ-017 mem_din  in  8  read byte from the RAM; valid one cycle after its address.
REQ-018 mem_wr  out  1  1 = write, 0 = read.

Function
REQ-019 States: IDLE, BUSY, DONE; a 2-bit byte counter; a 1-bit last_grant flag (IF or D).
REQ-020 IDLE arbitration at each edge:
- only one of d_req, (if_req & ~if_flush) high -> grant that port;
- both high -> grant the port opposite last_grant;
- after reset, last_grant = IF, so D wins the first tie.
REQ-021 On grant: latch address, size (IF = 4 bytes), we and wdata; set counter = 0; enter BUSY; update last_grant.
REQ-022 BUSY address cycle i (i = 0..N-1): mem_addr = (latched addr + i)[16:0]; 17-bit wrap from 0x1FFFF to 0x00000 is permitted.
REQ-023 BUSY write: mem_wr = 1, mem_dout = byte i of wdata; after byte N-1, enter DONE.
REQ-024 BUSY read:
- mem_wr = 0;
- mem_din is captured into byte i-1 of the assembly register in cycle i;
- one extra cycle captures byte N-1, then DONE.
REQ-025 DONE lasts exactly one cycle: pulse if_done or d_done for the granted port, drive assembled data, grant nothing, return to IDLE.
REQ-026 Latency from the request-sampling edge (cycle 0) to the done cycle:
- word read = cycle 6, half read = cycle 4, byte read = cycle 3;
- word write = cycle 5, byte write = cycle 2.
REQ-027 Requesters deassert req in the cycle after done; a req still high in that cycle (IDLE) starts a new transaction.
REQ-028 Once granted, a transaction runs to completion; no preemption.
REQ-029 if_flush high during an IF BUSY: return to IDLE at that edge, with no if_done and a discarded assembly register.
REQ-030 if_flush has no effect on D transactions or on an IF DONE cycle; the fetch unit discards that if_done.
REQ-031 Outputs outside BUSY/DONE:
- mem_wr = 0, mem_addr = 0, mem_dout = 0;
- if_done and d_done = 0;
- if_inst and d_rdata hold their last value.

Reset
REQ-032 rst low immediately forces: state IDLE, counter 0, last_grant IF, all outputs 0 (mem_wr = 0); this applies mid-write as well, so a store may be left partially written.
REQ-033 After rst rises, the first grant is possible at the first clock edge.

Verification
REQ-034 Word fetch: if_addr 0x00000010, RAM[0x10..0x13] = 13,05,00,00 -> mem_addr 0x10..0x13 in cycles 1-4, mem_wr = 0, if_done with if_inst 0x00000513 in cycle 6.
REQ-035 Byte store then load:
- store d_size 00, d_addr 0x00104, d_wdata 0xDEADBEEF -> single write of 0xEF in cycle 1, d_done in cycle 2;
- load of the same address -> d_rdata 0x000000EF.
REQ-036 Tie and alternation: if_req and d_req both held high from reset -> D, then IF, then D granted; no port waits more than one transaction.
REQ-037 Flush abort: if_flush pulsed in cycle 3 of a fetch -> no if_done, IDLE in cycle 4; a concurrent d_req is granted at that edge.
REQ-038 Wrap: word load at d_addr 0x0001FFFE -> mem_addr 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
REQ-039 Reset mid-word-write (rst low in cycle 2) -> mem_wr = 0 asynchronously, no d_done; after release, a new request completes normally.
